// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response bundle.
// Single outstanding valid/ready request, rvalid response.
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns fetch PC, one outstanding imem request,
// one-entry stall buffer, redirect kill of in-flight responses.
module instruction_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    bp_taken,
  input  logic [XLEN-1:0]         bp_target,
  instruction_fetch_unit_if.master imem,
  output logic                    IF_valid,
  output logic [XLEN-1:0]         IF_pc,
  output logic [XLEN-1:0]         IF_pc_plus_4,
  output logic [31:0]             IF_instruction,
  output logic                    IF_branch_estimation
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE, WAIT, KILL, HOLD
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            est;
  } fetch_t;

  state_t          state, state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            req_est;
  fetch_t          buf_q;

  logic slot_free;
  logic accept;
  logic load_out;
  logic load_buf;
  logic pop_buf;
  logic bubble;

  assign slot_free = !IF_valid || !stall;
  assign imem.addr = fetch_pc;
  assign imem.req  = reset && !redirect_valid &&
                     (state == IDLE ||
                      (state == WAIT && imem.rvalid && slot_free));
  assign accept    = imem.req && imem.ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and datapath controls
  always_comb begin
    state_n  = state;
    load_out = 1'b0;
    load_buf = 1'b0;
    pop_buf  = 1'b0;
    bubble   = 1'b0;
    if (redirect_valid) begin
      if ((state == WAIT || state == KILL) && !imem.rvalid)
        state_n = KILL;
      else
        state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          bubble = !stall;
          if (accept) state_n = WAIT;
        end
        WAIT: begin
          if (imem.rvalid && slot_free) begin
            load_out = 1'b1;
            state_n  = accept ? WAIT : IDLE;
          end else if (imem.rvalid) begin
            load_buf = 1'b1;
            state_n  = HOLD;
          end else begin
            bubble = !stall;
          end
        end
        KILL: begin
          bubble = !stall;
          if (imem.rvalid) state_n = IDLE;
        end
        HOLD: begin
          if (!stall) begin
            pop_buf = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Fetch PC and request context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_VECTOR;
      req_pc   <= '0;
      req_est  <= 1'b0;
    end else begin
      if (redirect_valid)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept)
        fetch_pc <= bp_taken ? bp_target
                             : fetch_pc + XLEN'(4);
      if (accept) begin
        req_pc  <= fetch_pc;
        req_est <= bp_taken;
      end
    end
  end

  // IF/ID outputs and stall buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IF_valid             <= 1'b0;
      IF_pc                <= '0;
      IF_pc_plus_4         <= '0;
      IF_instruction       <= NOP;
      IF_branch_estimation <= 1'b0;
      buf_q                <= '0;
    end else if (redirect_valid) begin
      IF_valid <= 1'b0;
      buf_q    <= '0;
    end else if (load_out) begin
      IF_valid             <= 1'b1;
      IF_pc                <= req_pc;
      IF_pc_plus_4         <= req_pc + XLEN'(4);
      IF_instruction       <= imem.rdata;
      IF_branch_estimation <= req_est;
    end else if (pop_buf) begin
      IF_valid             <= 1'b1;
      IF_pc                <= buf_q.pc;
      IF_pc_plus_4         <= buf_q.pc + XLEN'(4);
      IF_instruction       <= buf_q.instr;
      IF_branch_estimation <= buf_q.est;
      buf_q                <= '0;
    end else if (load_buf) begin
      buf_q <= '{pc: req_pc, instr: imem.rdata, est: req_est};
    end else if (bubble) begin
      IF_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Memory returns 32'h1000_0000 | addr one cycle after accept.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        IF_valid;
  logic [31:0] IF_pc;
  logic [31:0] IF_pc_plus_4;
  logic [31:0] IF_instruction;
  logic        IF_branch_estimation;

  logic        mem_ready;
  logic        mem_hold;
  logic        pend;
  logic [31:0] paddr;

  int vec_cnt = 0;
  int err_cnt = 0;

  instruction_fetch_unit_if #(.XLEN(32)) imem ();

  instruction_fetch_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .bp_taken             (bp_taken),
    .bp_target            (bp_target),
    .imem                 (imem.master),
    .IF_valid             (IF_valid),
    .IF_pc                (IF_pc),
    .IF_pc_plus_4         (IF_pc_plus_4),
    .IF_instruction       (IF_instruction),
    .IF_branch_estimation (IF_branch_estimation)
  );

  always #5 clk = ~clk;

  assign imem.ready  = mem_ready;
  assign imem.rvalid = pend && !mem_hold;
  assign imem.rdata  = 32'h1000_0000 | paddr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend  <= 1'b0;
      paddr <= '0;
    end else if (imem.req && imem.ready) begin
      pend  <= 1'b1;
      paddr <= imem.addr;
    end else if (imem.rvalid) begin
      pend <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_v"},   32'(IF_valid), 32'd0);
    chk({tag, "_pc"},  IF_pc, 32'h0);
    chk({tag, "_pc4"}, IF_pc_plus_4, 32'h0);
    chk({tag, "_ins"}, IF_instruction, 32'h0000_0013);
    chk({tag, "_est"}, 32'(IF_branch_estimation), 32'd0);
    chk({tag, "_req"}, 32'(imem.req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; bp_taken = 1'b0; bp_target = '0;
    mem_ready = 1'b1; mem_hold = 1'b0;
    #2 reset = 1'b0;
    #1 chk_rst("rst");
    tick();
    chk_rst("rst_hold");
    #2 reset = 1'b1;
    #1;
    chk("first_req", 32'(imem.req), 32'd1);
    chk("first_addr", imem.addr, 32'h0);

    tick();
    chk("p1_addr", imem.addr, 32'h4);
    chk("p1_v", 32'(IF_valid), 32'd0);
    tick();
    chk("p2_v", 32'(IF_valid), 32'd1);
    chk("p2_pc", IF_pc, 32'h0);
    chk("p2_ins", IF_instruction, 32'h1000_0000);
    chk("p2_addr", imem.addr, 32'h8);

    bp_taken = 1'b1; bp_target = 32'h40;
    tick();
    bp_taken = 1'b0; bp_target = '0;
    chk("p3_pc", IF_pc, 32'h4);
    chk("bp_addr", imem.addr, 32'h40);
    tick();
    chk("p4_pc", IF_pc, 32'h8);
    chk("p4_pc4", IF_pc_plus_4, 32'hC);
    chk("p4_est", 32'(IF_branch_estimation), 32'd1);
    chk("p4_addr", imem.addr, 32'h44);

    stall = 1'b1;
    #1 chk("stall_req", 32'(imem.req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", IF_pc, 32'h8);
      chk("stall_v", 32'(IF_valid), 32'd1);
      chk("stall_req", 32'(imem.req), 32'd0);
    end
    stall = 1'b0;
    #1 chk("hold_req", 32'(imem.req), 32'd0);
    tick();
    chk("unst_pc", IF_pc, 32'h40);
    chk("unst_ins", IF_instruction, 32'h1000_0040);
    chk("unst_est", 32'(IF_branch_estimation), 32'd0);
    chk("unst_addr", imem.addr, 32'h44);
    tick();
    chk("bub_v", 32'(IF_valid), 32'd0);
    chk("bub_addr", imem.addr, 32'h48);

    mem_hold = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("kill_v", 32'(IF_valid), 32'd0);
    chk("kill_req", 32'(imem.req), 32'd0);
    mem_hold = 1'b0;
    #1 chk("kill_req2", 32'(imem.req), 32'd0);
    tick();
    chk("kdone_v", 32'(IF_valid), 32'd0);
    chk("kdone_req", 32'(imem.req), 32'd1);
    chk("kdone_addr", imem.addr, 32'h100);
    tick();
    chk("rd1_v", 32'(IF_valid), 32'd0);
    tick();
    chk("rd2_v", 32'(IF_valid), 32'd1);
    chk("rd2_pc", IF_pc, 32'h100);
    chk("rd2_ins", IF_instruction, 32'h1000_0100);
    chk("rd2_addr", imem.addr, 32'h108);

    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nrdy_req", 32'(imem.req), 32'd1);
      chk("nrdy_addr", imem.addr, 32'h108);
    end
    chk("nrdy_v", 32'(IF_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("nrdy_redir", imem.addr, 32'h200);
    chk("nrdy_rreq", 32'(imem.req), 32'd1);
    mem_ready = 1'b1;
    tick();
    tick();
    chk("r200_v", 32'(IF_valid), 32'd1);
    chk("r200_pc", IF_pc, 32'h200);
    chk("r200_ins", IF_instruction, 32'h1000_0200);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_v", 32'(IF_valid), 32'd0);
    chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_next", imem.addr, 32'h0);
    tick();
    chk("wrap_pc", IF_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", IF_pc_plus_4, 32'h0);
    chk("wrap_ins", IF_instruction, 32'hFFFF_FFFC);

    #2 reset = 1'b0;
    #1 chk_rst("mid_rst");
    tick();
    #1 reset = 1'b1;
    #1;
    chk("rst_req", 32'(imem.req), 32'd1);
    chk("rst_addr", imem.addr, 32'h0);
    tick();
    tick();
    chk("rst_v", 32'(IF_valid), 32'd1);
    chk("rst_pc", IF_pc, 32'h0);
    chk("rst_ins", IF_instruction, 32'h1000_0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
